// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder and the load alignment unit.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    case (size)
      MEM_B:   size_bytes = 4'd1;
      MEM_H:   size_bytes = 4'd2;
      MEM_W:   size_bytes = 4'd4;
      MEM_D:   size_bytes = 4'd8;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input mem_size_e size);
    case (size)
      MEM_B:   size_mask = 3'd0;
      MEM_H:   size_mask = 3'd1;
      MEM_W:   size_mask = 3'd3;
      MEM_D:   size_mask = 3'd7;
      default: size_mask = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_align_extend.sv
// Picks the addressed bytes out of an aligned doubleword and sign/zero-extends them to 64 bits.
module load_align_extend
  import data_mem_responder_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [2:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted_s;

  // Shift the addressed byte down to lane 0, then extend from the access size.
  always_comb begin
    shifted_s = raw_i >> {offset_i, 3'b000};
    result_o  = 64'd0;
    case (size_i)
      MEM_B: begin
        if (unsigned_i) begin
          result_o = {56'd0, shifted_s[7:0]};
        end else begin
          result_o = {{56{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      MEM_H: begin
        if (unsigned_i) begin
          result_o = {48'd0, shifted_s[15:0]};
        end else begin
          result_o = {{48{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      MEM_W: begin
        if (unsigned_i) begin
          result_o = {32'd0, shifted_s[31:0]};
        end else begin
          result_o = {{32{shifted_s[31]}}, shifted_s[31:0]};
        end
      end
      MEM_D:   result_o = shifted_s;
      default: result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: valid/ready request, WAIT_STATES delay, held response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW       = $clog2(DEPTH_BYTES);
  localparam int AW1      = AW + 1;
  localparam int CW       = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int CNT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  logic [7:0]    mem_q [DEPTH_BYTES];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          write_q;
  logic [63:0]   addr_q;
  mem_size_e     size_q;
  logic          unsigned_q;
  logic [63:0]   wdata_q;

  logic          accept_s;
  logic          enter_resp_s;
  logic          op_write_s;
  logic [63:0]   op_addr_s;
  mem_size_e     op_size_s;
  logic          op_unsigned_s;
  logic [63:0]   op_wdata_s;
  logic [3:0]    op_nbytes_s;
  logic          op_err_s;
  logic [AW1-1:0] end_s;
  logic [AW-1:0] op_idx_s;
  logic [AW-1:0] base_s;
  logic [63:0]   raw_s;
  logic [63:0]   ext_s;

  assign accept_s = req_valid & ready_q;

  // With zero wait states RESP is entered on the accept edge, so the live request is used then.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_write_s    = req_write;
      op_addr_s     = req_addr;
      op_size_s     = mem_size_e'(req_size);
      op_unsigned_s = req_unsigned;
      op_wdata_s    = req_wdata;
    end else begin
      op_write_s    = write_q;
      op_addr_s     = addr_q;
      op_size_s     = size_q;
      op_unsigned_s = unsigned_q;
      op_wdata_s    = wdata_q;
    end
  end

  // Error classification and aligned-doubleword fetch for the current operation.
  always_comb begin
    op_nbytes_s = size_bytes(op_size_s);
    op_idx_s    = op_addr_s[AW-1:0];
    base_s      = op_idx_s & ~AW'(3'd7);
    end_s       = {1'b0, op_idx_s} + AW1'(op_nbytes_s);
    op_err_s    = ((op_addr_s[2:0] & size_mask(op_size_s)) != 3'd0)
                | ((op_addr_s >> AW) != 64'd0)
                | (end_s > AW1'(DEPTH_BYTES));
    raw_s       = 64'd0;
    for (int i = 0; i < 8; i++) begin
      raw_s[8*i +: 8] = mem_q[base_s + AW'(i)];
    end
  end

  load_align_extend u_load_align_extend (
    .raw_i      (raw_s),
    .offset_i   (op_addr_s[2:0]),
    .size_i     (op_size_s),
    .unsigned_i (op_unsigned_s),
    .result_o   (ext_s)
  );

  // Next-state logic and registered-output next values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES == 0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(CNT_INIT);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    if (enter_resp_s) begin
      err_d   = op_err_s ? RSP_ERR : RSP_OK;
      rdata_d = (op_err_s || op_write_s) ? 64'd0 : ext_s;
    end else if (state_d == ST_IDLE) begin
      err_d   = RSP_OK;
      rdata_d = 64'd0;
    end else begin
      err_d   = err_q;
      rdata_d = rdata_q;
    end
  end

  // Control and response registers; request fields captured on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= RSP_OK;
      write_q    <= 1'b0;
      addr_q     <= 64'd0;
      size_q     <= MEM_B;
      unsigned_q <= 1'b0;
      wdata_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept_s) begin
        write_q    <= req_write;
        addr_q     <= req_addr;
        size_q     <= mem_size_e'(req_size);
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
      end
    end
  end

  // Storage is not reset; a store commits once, on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp_s && op_write_s && !op_err_s) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(op_nbytes_s)) begin
          mem_q[op_idx_s + AW'(i)] <= op_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random traffic vs. a byte-array model.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [1:0]  s;
    logic        u;
    logic [63:0] d;
    logic [63:0] exp_rd;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory with natural alignment and bounds rules.
  function automatic void model(input logic w, input logic [63:0] a, input logic [1:0] s,
                                input logic u, input logic [63:0] d,
                                output logic [63:0] rd, output logic e);
    int nb;
    logic [63:0] val;
    nb  = 1 << s;
    e   = ((a % 64'(nb)) != 64'd0) || (a > 64'(DEPTH - nb));
    rd  = 64'd0;
    val = 64'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) val = val | (64'(ref_mem[int'(a) + i]) << (8 * i));
        if (!u && nb < 8 && val[8*nb-1]) val = val | ~((64'd1 << (8 * nb)) - 64'd1);
        rd = val;
      end
    end
  endfunction

  function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [1:0] s,
                              input logic u, input logic [63:0] d,
                              input logic [63:0] exp_rd, input logic exp_e);
    vec_t v;
    v.w = w; v.a = a; v.s = s; v.u = u; v.d = d; v.exp_rd = exp_rd; v.exp_e = exp_e;
    return v;
  endfunction

  // Drive a request and return at the first falling edge after it is accepted.
  task automatic send(input logic w, input logic [63:0] a, input logic [1:0] s,
                      input logic u, input logic [63:0] d);
    int n;
    @(negedge clk);
    req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check64("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response (latency checked), optionally hold it, then hand-shake it away.
  task automatic get_rsp(input int hold, output logic [63:0] rd, output logic e);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check64("latency", 64'(lat), 64'(WS + 1));
    rd = rsp_rdata;
    e  = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check64("hold_valid", 64'(rsp_valid), 64'd1);
      check64("hold_rdata", rsp_rdata, rd);
      check64("hold_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check64("rsp_drop", 64'(rsp_valid), 64'd0);
    check64("ready_back", 64'(req_ready), 64'd1);
  endtask

  task automatic txn(input string name, input logic w, input logic [63:0] a, input logic [1:0] s,
                     input logic u, input logic [63:0] d, input logic [63:0] exp_rd,
                     input logic exp_e, input int hold);
    logic [63:0] rd;
    logic        e;
    send(w, a, s, u, d);
    get_rsp(hold, rd, e);
    check64({name, "_rdata"}, rd, exp_rd);
    check64({name, "_err"}, 64'(e), 64'(exp_e));
  endtask

  initial begin
    logic [63:0] d, mrd, rd1, exp_rd;
    logic        me, e1;
    logic [63:0] a;
    logic [1:0]  s;
    logic        w, u;
    int          r;

    // Reset, then five idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("idle_req_ready", 64'(req_ready), 64'd1);
      check64("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      check64("idle_rsp_rdata", rsp_rdata, 64'd0);
      check64("idle_rsp_err", 64'(rsp_err), 64'd0);
    end

    // Fill memory so that each byte holds its own address.
    for (int k = 0; k < DEPTH / 8; k++) begin
      for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8 * k + b);
      model(1'b1, 64'(8 * k), 2'd3, 1'b0, d, mrd, me);
      txn("init_sd", 1'b1, 64'(8 * k), 2'd3, 1'b0, d, 64'd0, 1'b0, 0);
    end

    tbl.push_back(mk(1'b1, 64'h10, 2'd3, 1'b0, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0));
    tbl.push_back(mk(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0));
    tbl.push_back(mk(1'b1, 64'h21, 2'd0, 1'b0, 64'h80, 64'd0, 1'b0));
    tbl.push_back(mk(1'b0, 64'h21, 2'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0));
    tbl.push_back(mk(1'b0, 64'h21, 2'd0, 1'b1, 64'd0, 64'h80, 1'b0));
    tbl.push_back(mk(1'b0, 64'h20, 2'd1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_8020, 1'b0));
    tbl.push_back(mk(1'b0, 64'h12, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1));
    tbl.push_back(mk(1'b1, 64'h40, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 64'h38, 2'd3, 1'b0, 64'd0, 64'h3F3E3D3C_3B3A3938, 1'b0));
    tbl.push_back(mk(1'b0, 64'h14, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0));
    tbl.push_back(mk(1'b0, 64'h14, 2'd2, 1'b1, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0));
    tbl.push_back(mk(1'b0, 64'h100, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1));
    tbl.push_back(mk(1'b1, 64'h3E, 2'd1, 1'b0, 64'h1234_5678_ABCD, 64'd0, 1'b0));
    tbl.push_back(mk(1'b0, 64'h3E, 2'd1, 1'b1, 64'd0, 64'h0000_0000_0000_ABCD, 1'b0));
    tbl.push_back(mk(1'b0, 64'h3E, 2'd1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0));
    tbl.push_back(mk(1'b0, 64'h3F, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 64'h3C, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 64'h38, 2'd3, 1'b1, 64'd0, 64'hABCD3D3C_3B3A3938, 1'b0));
    tbl.push_back(mk(1'b0, 64'h00, 2'd0, 1'b0, 64'd0, 64'h0, 1'b0));
    tbl.push_back(mk(1'b0, 64'h02, 2'd1, 1'b0, 64'd0, 64'h0302, 1'b0));
    tbl.push_back(mk(1'b1, 64'h3C, 2'd2, 1'b0, 64'h8000_0001, 64'd0, 1'b0));
    tbl.push_back(mk(1'b0, 64'h3C, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0));

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].d, mrd, me);
      txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].d,
          tbl[i].exp_rd, tbl[i].exp_e, i % 2);
    end

    // Backpressure: response held 4 cycles while a second request waits.
    send(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);
    r = 1;
    while (!rsp_valid && r < 40) begin
      @(negedge clk);
      r++;
    end
    check64("bp_latency", 64'(r), 64'(WS + 1));
    rd1 = rsp_rdata;
    check64("bp_first_rdata", rd1, 64'hDEADBEEF_CAFEF00D);
    req_write = 1'b0; req_addr = 64'h10; req_size = 2'd2; req_unsigned = 1'b0;
    req_valid = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check64("bp_valid", 64'(rsp_valid), 64'd1);
      check64("bp_rdata_stable", rsp_rdata, rd1);
      check64("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check64("bp_after_hs_ready", 64'(req_ready), 64'd1);
    check64("bp_after_hs_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    get_rsp(0, rd1, e1);
    check64("bp_second_rdata", rd1, 64'hFFFF_FFFF_CAFE_F00D);
    check64("bp_second_err", 64'(e1), 64'd0);

    // Reset lands on the edge that would commit a store: nothing written, no response.
    send(1'b1, 64'h8, 2'd2, 1'b0, 64'h1234);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check64("rst_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check64("rst_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    txn("rst_old", 1'b0, 64'h8, 2'd2, 1'b0, 64'd0, 64'h0B0A0908, 1'b0, 0);

    // Random traffic against the model.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      if (r == 0) begin
        a = {$urandom, $urandom};
      end else begin
        a = 64'($urandom_range(0, DEPTH + 7));
        if (r < 8) a = a & ~((64'd1 << s) - 64'd1);
      end
      model(w, a, s, u, d, exp_rd, me);
      txn("rand", w, a, s, u, d, exp_rd, me, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
